mux_3_sel: RTL and testbench

//   ALU operand-B source select for the 16-bit RISC CPU datapath.

---
 rtl/mux_3_sel_if.sv | 56 +++++
 rtl/mux_3_sel.sv | 56 +++++
 tb/tb_mux_3_sel.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mux_3_sel_if.sv
// ---------------------------------------------------------------------------
// mux_3_sel_if
//   Bundle of the ALU operand-B select signals between the decode/register
//   read stage (master) and the operand-B select block (slave).
//
//   Signals
//     M3               master -> slave  1  select: 1 = immediate, 0 = register
//     Sign_ext_1_out   master -> slave  N  sign-extended immediate
//     Reg_read_data_2  master -> slave  N  register file read port 2
//     en               master -> slave  1  pipeline advance (0 = hold)
//     flush            master -> slave  1  synchronous bubble insert
//     MUX_3_out        slave  -> master N  combinational selected operand
//     MUX_3_out_q      slave  -> master N  registered selected operand
//     sel_q            slave  -> master 1  registered copy of M3
//
//   Pipeline control semantics: there is no valid/ready pair. On each rising
//   clock edge, flush = 1 inserts a bubble (flush beats en), otherwise en = 1
//   captures the current selection and en = 0 stalls, holding the registered
//   outputs. The combinational output ignores en and flush entirely.
// ---------------------------------------------------------------------------
interface mux_3_sel_if #(
    parameter int N = 16
);
    logic         M3;
    logic [N-1:0] Sign_ext_1_out;
    logic [N-1:0] Reg_read_data_2;
    logic         en;
    logic         flush;
    logic [N-1:0] MUX_3_out;
    logic [N-1:0] MUX_3_out_q;
    logic         sel_q;

    // Decode / register-read side: drives select, sources and control.
    modport master (
        output M3,
        output Sign_ext_1_out,
        output Reg_read_data_2,
        output en,
        output flush,
        input  MUX_3_out,
        input  MUX_3_out_q,
        input  sel_q
    );

    // Operand-B select block.
    modport slave (
        input  M3,
        input  Sign_ext_1_out,
        input  Reg_read_data_2,
        input  en,
        input  flush,
        output MUX_3_out,
        output MUX_3_out_q,
        output sel_q
    );
endinterface

// File: rtl/mux_3_sel.sv
// ---------------------------------------------------------------------------
// mux_3_sel
//   ALU operand-B source select for the 16-bit RISC datapath. Chooses between
//   register-file read port 2 and the sign-extended immediate.
//     - MUX_3_out   : combinational, same-cycle feed to the ALU.
//     - MUX_3_out_q : registered copy with hold (en = 0) and flush, feeding
//                     the EX pipeline register.
//     - sel_q       : registered copy of M3 for debug / hazard logic.
//
//   Ports
//     clk  in  1   system clock, rising edge
//     rst  in  1   asynchronous, active-high reset (clears MUX_3_out_q, sel_q)
//     bus  slave modport of mux_3_sel_if (select, sources, en, flush, outputs)
//
//   Parameters
//     N          data width of both sources and outputs
//     FLUSH_VAL  value loaded into MUX_3_out_q on flush
// ---------------------------------------------------------------------------
module mux_3_sel #(
    parameter int           N         = 16,
    parameter logic [N-1:0] FLUSH_VAL = '0
) (
    input  logic        clk,
    input  logic        rst,
    mux_3_sel_if.slave  bus
);

    logic [N-1:0] w_mux_out;
    logic [N-1:0] r_mux_out_q;
    logic         r_sel_q;

    // Ternary rather than case/default: an unknown M3 propagates X to the
    // output instead of being masked onto one of the sources.
    always_comb begin
        w_mux_out = bus.M3 ? bus.Sign_ext_1_out : bus.Reg_read_data_2;
    end

    // Priority: reset, then flush (bubble wins over advance), then en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mux_out_q <= '0;
            r_sel_q     <= 1'b0;
        end else if (bus.flush) begin
            r_mux_out_q <= FLUSH_VAL;
            r_sel_q     <= 1'b0;
        end else if (bus.en) begin
            r_mux_out_q <= w_mux_out;
            r_sel_q     <= bus.M3;
        end
    end

    assign bus.MUX_3_out   = w_mux_out;
    assign bus.MUX_3_out_q = r_mux_out_q;
    assign bus.sel_q       = r_sel_q;

endmodule

// File: tb/tb_mux_3_sel.sv
// ---------------------------------------------------------------------------
// tb_mux_3_sel
//   Self-checking bench for mux_3_sel: directed scenarios followed by random
//   cycles, checked against a behavioural model of the select and of the
//   registered stage.
// ---------------------------------------------------------------------------
module tb_mux_3_sel;

    localparam int           N         = 16;
    localparam logic [N-1:0] FLUSH_VAL = '0;

    // ---------------- clock / reset ----------------
    logic clk     = 1'b0;
    logic rst     = 1'b1;
    bit   clk_run = 1'b0;

    always #5 if (clk_run) clk = ~clk;

    mux_3_sel_if #(.N(N)) bus ();

    mux_3_sel #(
        .N         (N),
        .FLUSH_VAL (FLUSH_VAL)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;

    // Shadow copies of what the bench drives.
    logic         drv_m3;
    logic [N-1:0] drv_imm;
    logic [N-1:0] drv_reg;
    logic         drv_en;
    logic         drv_flush;

    // Reference model of the registered stage.
    logic [N-1:0] m_q;
    logic         m_sel;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Selected source looked up from a two-entry table indexed by the select.
    function automatic logic [N-1:0] ref_mux(input logic m3, input logic [N-1:0] imm,
                                             input logic [N-1:0] rd);
        logic [N-1:0] src [2];
        src[0] = rd;
        src[1] = imm;
        return src[m3];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_inputs(input logic m3, input logic [N-1:0] imm, input logic [N-1:0] rd,
                              input logic en, input logic fl);
        drv_m3    = m3;
        drv_imm   = imm;
        drv_reg   = rd;
        drv_en    = en;
        drv_flush = fl;
        bus.M3              = m3;
        bus.Sign_ext_1_out  = imm;
        bus.Reg_read_data_2 = rd;
        bus.en              = en;
        bus.flush           = fl;
    endtask

    task automatic check_comb(input string tag);
        #1;
        check_eq(tag, 32'(bus.MUX_3_out), 32'(ref_mux(drv_m3, drv_imm, drv_reg)));
    endtask

    task automatic check_regs(input string tag);
        check_eq({tag, "_q"},   32'(bus.MUX_3_out_q), 32'(m_q));
        check_eq({tag, "_sel"}, 32'(bus.sel_q),       32'(m_sel));
    endtask

    // One rising edge: update the model from the values present at the edge,
    // then compare shortly after it.
    task automatic clock_step(input string tag);
        @(posedge clk);
        if (!rst) begin
            if (drv_flush) begin
                m_q   = FLUSH_VAL;
                m_sel = 1'b0;
            end else if (drv_en) begin
                m_q   = ref_mux(drv_m3, drv_imm, drv_reg);
                m_sel = drv_m3;
            end
        end
        #1;
        check_regs(tag);
    endtask

    task automatic assert_rst(input string tag);
        rst   = 1'b1;
        m_q   = '0;
        m_sel = 1'b0;
        #1;
        check_regs(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        m_q   = '0;
        m_sel = 1'b0;

        // Scenario 1: combinational path with no clock running, in reset.
        set_inputs(1'b0, 16'd20, 16'd10, 1'b0, 1'b0);
        check_comb("t1_reg_sel");
        check_eq("t1_reg_val", 32'(bus.MUX_3_out), 32'd10);
        check_regs("reset");
        #3;                                   // t = 4
        set_inputs(1'b1, 16'd20, 16'd10, 1'b0, 1'b0);
        check_comb("t1_imm_sel");             // t = 5, still no clock
        check_eq("t1_imm_val", 32'(bus.MUX_3_out), 32'd20);

        // Release reset and start the clock; first edge at t = 10.
        #1 rst = 1'b0;
        clk_run = 1'b1;

        // Scenario 3: capture 0xFFFF from the immediate, latency one edge.
        set_inputs(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
        #1;
        check_regs("t3_pre_edge");
        clock_step("t3_capture");
        check_eq("t3_q_val", 32'(bus.MUX_3_out_q), 32'hFFFF);

        // Scenario 2: reset pulse mid-cycle with 0x1234 registered.
        @(negedge clk);
        set_inputs(1'b0, 16'h0000, 16'h1234, 1'b1, 1'b0);
        clock_step("t2_load");
        @(negedge clk);
        #2;
        assert_rst("t2_async_rst");
        set_inputs(1'b1, 16'h0BAD, 16'h1234, 1'b1, 1'b0);
        check_comb("t2_comb_in_rst");
        clock_step("t2_held_in_rst");
        @(negedge clk);
        rst = 1'b0;
        set_inputs(1'b1, 16'h0777, 16'h1234, 1'b1, 1'b0);
        clock_step("t2_first_capture");

        // Scenario 4: stall over three edges while inputs change.
        @(negedge clk);
        set_inputs(1'b0, 16'h0000, 16'h5555, 1'b1, 1'b0);
        clock_step("t4_load");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_inputs(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'b0, 1'b0);
            check_comb("t4_comb_follow");
            clock_step("t4_hold");
        end
        check_eq("t4_hold_val", 32'(bus.MUX_3_out_q), 32'h5555);

        // Scenario 5: flush and en together; sel_q was 1 beforehand.
        @(negedge clk);
        set_inputs(1'b1, 16'h2468, 16'h0000, 1'b1, 1'b0);
        clock_step("t5_prep");
        @(negedge clk);
        set_inputs(1'b1, 16'hABCD, 16'hABCD, 1'b1, 1'b1);
        clock_step("t5_flush");
        check_eq("t5_flush_val", 32'(bus.MUX_3_out_q), 32'(FLUSH_VAL));

        // Reset during a stall discards the held value.
        @(negedge clk);
        set_inputs(1'b0, 16'h0000, 16'h9876, 1'b1, 1'b0);
        clock_step("stall_rst_load");
        @(negedge clk);
        set_inputs(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0);
        #2;
        assert_rst("stall_rst_clear");
        @(negedge clk);
        rst = 1'b0;
        clock_step("stall_rst_after");

        // Scenario 6: walking-one patterns on both sources, both selects.
        for (int i = 0; i < N; i++) begin
            for (int s = 0; s < 2; s++) begin
                set_inputs(1'(s), 16'(1 << i), 16'(1 << ((i + 5) % N)), 1'b0, 1'b0);
                check_comb("t6_walk");
            end
        end

        // Random phase.
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            set_inputs(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                       1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0));
            check_comb("rnd_comb");
            if ($urandom_range(0, 19) == 0) begin
                #1;
                assert_rst("rnd_rst");
                clock_step("rnd_in_rst");
                @(negedge clk);
                rst = 1'b0;
            end
            clock_step("rnd_reg");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish by %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
